// File: rtl/grf_pkg.sv
// Shared CPU definitions: datapath width, register address width and the
// hard-wired zero register index. Also used by the ALU and the decoder.
package grf_pkg;

  localparam int DW       = 32;
  localparam int AW       = 5;
  localparam int REG_ZERO = 0;

endpackage

// File: rtl/grf.sv
// General register file: 2^AW x DW registers, two combinational read ports
// with optional same-cycle write forwarding, one write port, and a one-cycle
// delayed write trace. Register 0 always reads as zero.
module grf #(
  parameter int DW     = grf_pkg::DW,
  parameter int AW     = grf_pkg::AW,
  parameter int BYPASS = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          WE,
  input  logic [AW-1:0] A1,
  input  logic [AW-1:0] A2,
  input  logic [AW-1:0] A3,
  input  logic [DW-1:0] WD,
  input  logic [31:0]   WPC,
  output logic [DW-1:0] RD1,
  output logic [DW-1:0] RD2,
  output logic          TV,
  output logic [31:0]   TPC,
  output logic [AW-1:0] TA,
  output logic [DW-1:0] TD
);

  import grf_pkg::*;

  localparam int            NREG      = 1 << AW;
  localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];

  logic          tv_q,  tv_d;
  logic [31:0]   tpc_q, tpc_d;
  logic [AW-1:0] ta_q,  ta_d;
  logic [DW-1:0] td_q,  td_d;

  logic          wr_store;
  logic          wr_fwd;
  logic [DW-1:0] rd1;
  logic [DW-1:0] rd2;

  // A write that actually changes storage; reset always wins over WE, and
  // register 0 is never stored so it cannot be corrupted.
  assign wr_store = WE && !reset && (A3 != ZERO_ADDR);
  assign wr_fwd   = (BYPASS != 0) && wr_store;

  // Next storage contents: only the addressed register changes.
  always_comb begin
    regs_d = regs_q;
    if (wr_store) begin
      regs_d[A3] = WD;
    end
  end

  // Next trace: every accepted write (even to r0) emits a record; idle
  // cycles drop TV but keep the last record visible.
  always_comb begin
    tv_d  = 1'b0;
    tpc_d = tpc_q;
    ta_d  = ta_q;
    td_d  = td_q;
    if (WE) begin
      tv_d  = 1'b1;
      tpc_d = WPC;
      ta_d  = A3;
      td_d  = (A3 == ZERO_ADDR) ? '0 : WD;
    end
  end

  // State register: reset clears every register and the trace.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '{default: '0};
      tv_q   <= 1'b0;
      tpc_q  <= '0;
      ta_q   <= '0;
      td_q   <= '0;
    end else begin
      regs_q <= regs_d;
      tv_q   <= tv_d;
      tpc_q  <= tpc_d;
      ta_q   <= ta_d;
      td_q   <= td_d;
    end
  end

  // Read port 1: stored value, overridden by the in-flight write on a match.
  always_comb begin
    rd1 = (A1 == ZERO_ADDR) ? '0 : regs_q[A1];
    if (wr_fwd && (A1 == A3)) begin
      rd1 = WD;
    end
  end

  // Read port 2: identical rule, so equal addresses give equal data.
  always_comb begin
    rd2 = (A2 == ZERO_ADDR) ? '0 : regs_q[A2];
    if (wr_fwd && (A2 == A3)) begin
      rd2 = WD;
    end
  end

  assign RD1 = rd1;
  assign RD2 = rd2;
  assign TV  = tv_q;
  assign TPC = tpc_q;
  assign TA  = ta_q;
  assign TD  = td_q;

endmodule

// File: tb/tb_grf.sv
// Directed bench for grf: one forwarding build and one non-forwarding build
// driven by the same stimulus, each output checked against hand values.
module tb_grf;

  logic        clk = 1'b0;
  logic        reset;
  logic        WE;
  logic [4:0]  A1, A2, A3;
  logic [31:0] WD, WPC;

  logic [31:0] RD1, RD2, TPC, TD;
  logic        TV;
  logic [4:0]  TA;

  logic [31:0] nb_RD1, nb_RD2, nb_TPC, nb_TD;
  logic        nb_TV;
  logic [4:0]  nb_TA;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  grf #(.DW(32), .AW(5), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .WE(WE), .A1(A1), .A2(A2), .A3(A3),
    .WD(WD), .WPC(WPC), .RD1(RD1), .RD2(RD2), .TV(TV), .TPC(TPC),
    .TA(TA), .TD(TD)
  );

  grf #(.DW(32), .AW(5), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .WE(WE), .A1(A1), .A2(A2), .A3(A3),
    .WD(WD), .WPC(WPC), .RD1(nb_RD1), .RD2(nb_RD2), .TV(nb_TV), .TPC(nb_TPC),
    .TA(nb_TA), .TD(nb_TD)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and let outputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; WE = 1'b0; A1 = '0; A2 = '0; A3 = '0; WD = '0; WPC = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;

    // Reset state: every address reads 0, trace idle and cleared.
    for (int a = 0; a < 32; a++) begin
      A1 = 5'(a);
      #1;
      chk($sformatf("rst_rd1_r%0d", a), RD1, 32'h0);
    end
    chk("rst_tv",  {31'b0, TV}, 32'h0);
    chk("rst_tpc", TPC, 32'h0);
    chk("rst_ta",  {27'b0, TA}, 32'h0);
    chk("rst_td",  TD, 32'h0);
    $display("txn reset: all registers read 0, trace idle");

    // Write r5 with forwarding to port 1.
    WE = 1'b1; A3 = 5'd5; WD = 32'hf0000001; WPC = 32'h3000; A1 = 5'd5; A2 = 5'd0;
    #1;
    chk("w5_bypass_rd1", RD1, 32'hf0000001);
    chk("w5_rd2_r0",     RD2, 32'h0);
    chk("w5_nb_rd1_old", nb_RD1, 32'h0);
    tick();
    WE = 1'b0;
    #1;
    chk("w5_tv",  {31'b0, TV}, 32'h1);
    chk("w5_tpc", TPC, 32'h3000);
    chk("w5_ta",  {27'b0, TA}, 32'd5);
    chk("w5_td",  TD, 32'hf0000001);
    chk("w5_rd1_stored", RD1, 32'hf0000001);
    tick();
    chk("idle_tv",       {31'b0, TV}, 32'h0);
    chk("idle_tpc_hold", TPC, 32'h3000);
    chk("idle_td_hold",  TD, 32'hf0000001);
    $display("txn write r5=f0000001 pc=3000: forwarded, traced");

    // Write to r0: no storage change, trace shows zero data.
    WE = 1'b1; A3 = 5'd0; WD = 32'hdeadbeef; WPC = 32'h3004; A1 = 5'd0; A2 = 5'd0;
    #1;
    chk("w0_rd1", RD1, 32'h0);
    chk("w0_rd2", RD2, 32'h0);
    tick();
    WE = 1'b0;
    #1;
    chk("w0_rd1_after", RD1, 32'h0);
    chk("w0_rd2_after", RD2, 32'h0);
    chk("w0_tv",  {31'b0, TV}, 32'h1);
    chk("w0_tpc", TPC, 32'h3004);
    chk("w0_ta",  {27'b0, TA}, 32'h0);
    chk("w0_td",  TD, 32'h0);
    $display("txn write r0=deadbeef pc=3004: dropped, traced as 0");

    // Back-to-back writes to r7, read on both ports.
    WE = 1'b1; A3 = 5'd7; WD = 32'h1; WPC = 32'h3008; A1 = 5'd7; A2 = 5'd7;
    #1;
    chk("b2b_rd2_first", RD2, 32'h1);
    chk("b2b_rd1_eq",    RD1, 32'h1);
    tick();
    WD = 32'h2; WPC = 32'h300c;
    #1;
    chk("b2b_tr1_tv",  {31'b0, TV}, 32'h1);
    chk("b2b_tr1_tpc", TPC, 32'h3008);
    chk("b2b_tr1_td",  TD, 32'h1);
    chk("b2b_rd2_second", RD2, 32'h2);
    chk("b2b_rd1_second", RD1, 32'h2);
    chk("b2b_nb_rd2_old", nb_RD2, 32'h1);
    tick();
    WE = 1'b0;
    #1;
    chk("b2b_tr2_tv",  {31'b0, TV}, 32'h1);
    chk("b2b_tr2_tpc", TPC, 32'h300c);
    chk("b2b_tr2_ta",  {27'b0, TA}, 32'd7);
    chk("b2b_tr2_td",  TD, 32'h2);
    chk("b2b_rd2_final", RD2, 32'h2);
    $display("txn write r7=1 then r7=2: last wins, two traces");

    // Reset with simultaneous write: no forwarding, write dropped.
    reset = 1'b1; WE = 1'b1; A3 = 5'd9; WD = 32'h1; WPC = 32'h3010; A1 = 5'd9; A2 = 5'd5;
    #1;
    chk("rstw_rd1_nofwd", RD1, 32'h0);
    chk("rstw_rd2_stored", RD2, 32'hf0000001);
    tick();
    reset = 1'b0; WE = 1'b0;
    #1;
    chk("rstw_r9",  RD1, 32'h0);
    chk("rstw_r5_cleared", RD2, 32'h0);
    chk("rstw_tv",  {31'b0, TV}, 32'h0);
    chk("rstw_tpc", TPC, 32'h0);
    chk("rstw_ta",  {27'b0, TA}, 32'h0);
    chk("rstw_td",  TD, 32'h0);
    A1 = 5'd7;
    #1;
    chk("rstw_r7_cleared", RD1, 32'h0);
    $display("txn reset with write r9=1: write dropped, state cleared");

    // Non-forwarding build: old value during write cycle, new after edge.
    WE = 1'b1; A3 = 5'd3; WD = 32'h0001; WPC = 32'h3014; A1 = 5'd3; A2 = 5'd0;
    #1;
    chk("nb_rd1_write_cycle", nb_RD1, 32'h0);
    chk("byp_rd1_write_cycle", RD1, 32'h0001);
    tick();
    WE = 1'b0;
    #1;
    chk("nb_rd1_after", nb_RD1, 32'h0001);
    chk("nb_tv", {31'b0, nb_TV}, 32'h1);
    chk("nb_td", nb_TD, 32'h0001);
    $display("txn nobypass write r3=1: old in cycle, new after edge");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/grf.md
GRF -- requirements
Module: grf

Interface
REQ-001 Parameter DW, default 32, data width of each register and port.
REQ-002 Parameter AW, default 5, register address width; register count is 2^AW.
REQ-003 Parameter BYPASS, default 1, enables same-cycle write-to-read forwarding.
REQ-004 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-005 Port reset, input, 1, reset is synchronous and active-high.
REQ-006 Port WE, input, 1, write enable.
REQ-007 Port A1, input, AW, read address, port 1 (feeds ALU operand A).
REQ-008 Port A2, input, AW, read address, port 2 (feeds ALU operand B).
REQ-009 Port A3, input, AW, write address.
REQ-010 Port WD, input, DW, write data.
REQ-011 Port WPC, input, 32, PC of the writing instruction, trace only.
REQ-012 Port RD1, output, DW, read data, port 1.
REQ-013 Port RD2, output, DW, read data, port 2.
REQ-014 Port TV, output, 1, write-trace valid.
REQ-015 Port TPC, output, 32, write-trace PC.
REQ-016 Port TA, output, AW, write-trace register number.
REQ-017 Port TD, output, DW, write-trace data.

Function
REQ-018 Storage: 2^AW registers of DW bits; register 0 reads 0 always.
REQ-019 Write: on rising clk with WE=1, reset=0, A3!=0 -> reg[A3] <= WD.
REQ-020 Write with A3=0 -> no storage change; trace is still emitted (TD=0, TA=0).
REQ-021 Reads are combinational, zero latency: RD1 = reg[A1], RD2 = reg[A2].
REQ-022 Bypass (BYPASS=1): if WE=1, A3!=0 and A1==A3 -> RD1=WD in the same cycle; same rule for RD2 with A2.
REQ-023 Bypass off (BYPASS=0): RD shows the old value until the edge after the write.
REQ-024 A1==A2: both ports return identical data, including under bypass.
REQ-025 Bypass is suppressed while reset=1; RD1/RD2 then show stored contents.
REQ-026 Trace: on every edge with WE=1, reset=0 -> next cycle TV=1, TPC=WPC, TA=A3, TD=(A3==0 ? 0 : WD).
REQ-027 Trace: on an edge with WE=0 -> next cycle TV=0; TPC, TA and TD hold their previous values.
REQ-028 Back-to-back writes to the same register: the last write wins; one trace per write, in order.
REQ-029 No arithmetic; no X propagation from unwritten registers, because reset defines all of them.

Reset
REQ-030 Edge with reset=1 -> all registers 0, TV=0, TPC=0, TA=0, TD=0.
REQ-031 Reset takes priority over a simultaneous WE=1; that write is dropped and no trace is emitted.
REQ-032 After reset deasserts, RD1/RD2 read 0 for every address until written.
REQ-033 Reset mid-sequence discards all prior writes; no partial state survives.

Structure
REQ-034 DW, AW and the register-0 index are in the shared CPU definitions header, also used by alu and the decoder.
REQ-035 Single module with no sub-module; the bypass mux is inline for each read port.
REQ-036 Storage is an array indexed by address; the trace outputs are separate flops.

Verification
REQ-037 Reset, then read A1=0..31 -> RD1=0 everywhere; TV=0.
REQ-038 WE=1, A3=5, WD=32'hf0000001, WPC=32'h3000, A1=5 -> RD1=32'hf0000001 same cycle (bypass); next cycle TV=1, TPC=32'h3000, TA=5, TD=32'hf0000001.
REQ-039 WE=1, A3=0, WD=32'hdeadbeef, A1=A2=0 -> RD1=RD2=0 throughout; next cycle TV=1, TA=0, TD=0.
REQ-040 Write r7=1 then r7=2 on consecutive edges, A2=7 -> RD2=1 then 2; two traces in order.
REQ-041 WE=1, reset=1, A3=9, WD=32'h1 -> after the edge r9=0, TV=0.
REQ-042 BYPASS=0 build: write r3=32'h0001 with A1=3 -> RD1=0 in the write cycle, 32'h0001 after the edge.
